// File: rtl/autoenc_pkg.sv
// Shared definitions for the autoencoder datapath.
//   state_t : feeder sequencer states
//   LANES   : number of demux lanes fed round-robin
//   SEL_W   : width of the lane select
//   DATA_W  : default fixed-point word width
package autoenc_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int LANES  = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 16;
endpackage

// File: rtl/demux_feeder_if.sv
// Valid/ready word stream into the demux feeder.
//   in_data  : word payload
//   in_valid : payload valid (source drives)
//   in_ready : sink accepts this cycle (feeder drives)
// Modports: master = word source, slave = feeder.
interface demux_feeder_if #(parameter int DATA_W = autoenc_pkg::DATA_W);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/demux_feeder.sv
// Sequencer ahead of the 1-to-4 lane demux. Accepts words from a valid/ready
// stream, tags them round-robin with lanes 0..3, presents them registered with
// a one-cycle strobe, pauses after each four-word group until group_ack, and
// flags layer completion after NUM_GROUPS groups.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a layer (IDLE only)
//   in_if         : word stream (slave side)
//   group_ack     : downstream consumed the group (WAIT only)
//   demux_data    : registered word to the demux
//   demux_sel     : registered lane select
//   demux_strobe  : data/sel newly valid
//   group_done    : fourth word of a group presented
//   layer_done    : last group of the layer presented
//   busy          : sequencer not idle
module demux_feeder
  import autoenc_pkg::*;
#(
  parameter int DATA_W     = autoenc_pkg::DATA_W,
  parameter int NUM_GROUPS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  demux_feeder_if.slave      in_if,
  input  logic               group_ack,
  output logic [DATA_W-1:0]  demux_data,
  output logic [SEL_W-1:0]   demux_sel,
  output logic               demux_strobe,
  output logic               group_done,
  output logic               layer_done,
  output logic               busy
);
  localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
  localparam logic [GRP_W-1:0] LAST_GRP  = GRP_W'(NUM_GROUPS - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] lane;
  logic [GRP_W-1:0] group;
  logic             acc, grp_end, last_grp;

  // Ready is a pure state decode so the source never sees a path from in_valid.
  assign in_if.in_ready = (state == LOAD);
  assign busy           = (state != IDLE);

  assign acc      = in_if.in_valid && (state == LOAD);
  assign grp_end  = acc && (lane == LAST_LANE);
  assign last_grp = (group == LAST_GRP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LOAD;
      LOAD:    if (grp_end)   state_nxt = last_grp ? IDLE : WAIT;
      WAIT:    if (group_ack) state_nxt = LOAD;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: data/sel only move on acceptance so the demux never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane         <= '0;
      group        <= '0;
      demux_data   <= '0;
      demux_sel    <= '0;
      demux_strobe <= 1'b0;
      group_done   <= 1'b0;
      layer_done   <= 1'b0;
    end else begin
      demux_strobe <= acc;
      group_done   <= grp_end;
      layer_done   <= grp_end && last_grp;
      if (acc) begin
        demux_data <= in_if.in_data;
        demux_sel  <= lane;
        lane       <= lane + 1'b1;   // 2-bit wrap 3 -> 0
      end
      if (state == IDLE && start) begin
        lane  <= '0;
        group <= '0;
      end
      // lane has already wrapped to 0 on the fourth acceptance
      if (state == WAIT && group_ack) group <= group + 1'b1;
    end
  end
endmodule

// File: doc/demux_feeder.md
# demux_feeder

Sequencer that sits directly upstream of the 1-to-4 lane demux (demux_1_4) in the autoencoder datapath. It accepts a valid/ready stream of 16-bit fixed-point words, assigns them round-robin to lanes 0..3, and presents each word with its lane select and a one-cycle strobe. After each group of four words it pauses until the downstream neuron stage acknowledges the group. After NUM_GROUPS groups it signals layer completion.

## Interface
Parameters:
- DATA_W, 16, word width
- NUM_GROUPS, 2, four-word groups per layer (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a layer; honoured only in IDLE
- in_data  in  DATA_W  input word
- in_valid  in  1  in_data valid
- in_ready  out  1  feeder accepts this cycle
- group_ack  in  1  downstream has consumed the current group; honoured only in WAIT
- demux_data  out  DATA_W  registered word to demux
- demux_sel  out  2  registered lane select, 0..3
- demux_strobe  out  1  one-cycle pulse: demux_data/demux_sel newly valid
- group_done  out  1  one-cycle pulse: fourth word of a group presented
- layer_done  out  1  one-cycle pulse: last group of layer presented
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, WAIT.
- IDLE: start=1 → LOAD; lane=0, group=0. start in any other state is ignored.
- LOAD: in_ready=1. A word is accepted when in_valid && in_ready. On acceptance, demux_data←in_data, demux_sel←lane, and lane increments mod 4.
- Acceptance at lane=3 with group<NUM_GROUPS-1 → WAIT, and group_done pulses.
- Acceptance at lane=3 with group=NUM_GROUPS-1 → IDLE, and group_done and layer_done pulse together.
- WAIT: in_ready=0. group_ack=1 → LOAD, group+1, lane stays 0. group_ack outside WAIT is ignored.
- in_ready is combinational from state only (state==LOAD). It never depends on in_valid.
- demux_data and demux_sel hold their last values between strobes, so the demux outputs never glitch.
- Group counter width is max(1, $clog2(NUM_GROUPS)). Lane counter is 2 bits and wraps 3→0.
- Reset values: state=IDLE, lane=0, group=0, demux_data=0, demux_sel=0, all pulses 0, in_ready=0, busy=0.
- Reset mid-layer aborts immediately. No done pulses are emitted and partial groups are discarded.

## Timing
- Latency: word accepted in cycle N → demux_strobe, demux_data, demux_sel valid in cycle N+1.
- group_done and layer_done are asserted in the same cycle as the strobe of the fourth word.
- Throughput in LOAD is one word per cycle. in_valid gaps stall without penalty.
- Minimum group turnaround: last word accepted at N; state is WAIT at N+1; group_ack=1 at N+1 → in_ready=1 at N+2.
- After layer_done (cycle N+1, state already IDLE), start at N+1 → in_ready=1 at N+2.
- busy is registered state decode. It rises the cycle after start and falls in the layer_done cycle.

## Structure
- Shared package (autoenc_pkg):
  - state enum (IDLE/LOAD/WAIT)
  - LANES=4
  - SEL_W=2
  - default DATA_W=16
- Single flat module; no sub-module is warranted.
- Integration: demux_data→in, demux_sel→select of demux_1_4. Downstream neuron registers load on demux_strobe.

## Test plan
- Reset then start, feed 0x0001..0x0004 back-to-back:
  - strobes in 4 consecutive cycles, sel 0,1,2,3
  - group_done with the 4th strobe; state WAIT; in_ready=0
- In WAIT, hold group_ack low 5 cycles, then pulse it:
  - in_ready stays 0 until the cycle after ack
  - next group of words 0x0011..0x0014 goes to sel 0..3
- NUM_GROUPS=2, full layer:
  - layer_done and group_done both pulse with the 8th strobe
  - busy drops that cycle; a later in_valid is not accepted
- Random in_valid gaps (e.g. valid 1,0,0,1,1,0,1):
  - each accepted word appears exactly one cycle later
  - demux_data holds between strobes
- start and group_ack asserted while in LOAD: no effect on counters or state.
- rst_n asserted mid-group (after 2 words):
  - all outputs return to reset values asynchronously
  - no done pulse
  - after a new start, the first word goes to sel 0
